// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency sweep controller.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_FIXED  = 2'd2;

  localparam int DIV_MIN_DEF = 3;

endpackage

// File: rtl/sweep_step_calc.sv
// Next-divider calculation: one step toward target, clamped so it never passes target.
module sweep_step_calc #(
  parameter int DIV_W = 12
) (
  input  logic [DIV_W-1:0] cur,
  input  logic [DIV_W-1:0] step,
  input  logic [DIV_W-1:0] target,
  input  logic             dir_dn,
  output logic [DIV_W-1:0] next,
  output logic             at_target
);

  logic [DIV_W:0] sum;
  logic [DIV_W:0] diff;

  always_comb begin
    sum       = {1'b0, cur} + {1'b0, step};
    diff      = {1'b0, cur} - {1'b0, step};
    at_target = (cur == target);
    if (at_target) begin
      next = cur;
    end else if (dir_dn) begin
      // borrow in the extra bit means the step went below zero
      next = (diff[DIV_W] || (diff[DIV_W-1:0] < target)) ? target : diff[DIV_W-1:0];
    end else begin
      next = (sum[DIV_W] || (sum[DIV_W-1:0] > target)) ? target : sum[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Sweeps the sine generator divider from start to end, changing it only on waveform
// period boundaries (rising edge of cnt_zero) so the output stays phase-continuous.
module freq_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int               DIV_W     = 12,
  parameter int               PER_W     = 8,
  parameter int               DIV_MIN   = DIV_MIN_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(99)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_start,
  input  logic [DIV_W-1:0] div_end,
  input  logic [DIV_W-1:0] div_step,
  input  logic [PER_W-1:0] per_step,
  input  logic             cnt_zero,
  output logic [DIV_W-1:0] divider,
  output logic             busy,
  output logic             step_strobe,
  output logic             sweep_done
);

  state_t           state;
  logic             cnt_zero_q;
  logic             bnd;
  logic [DIV_W-1:0] start_s, tgt_s, oth_s, step_s;
  logic [PER_W-1:0] per_s, pcnt;
  logic             dir_dn_s, bounce_s, fixed_s;

  logic [DIV_W-1:0] start_c, end_c, eff_tgt, nxt;
  logic             at_tgt, bounce_turn, eff_dn, calc_at;

  assign bnd     = cnt_zero & ~cnt_zero_q;
  assign start_c = (div_start < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_start;
  assign end_c   = (div_end < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_end;

  // On a bounce turnaround the step is taken toward the opposite end in the same period.
  assign at_tgt      = (divider == tgt_s);
  assign bounce_turn = at_tgt & bounce_s;
  assign eff_tgt     = bounce_turn ? oth_s : tgt_s;
  assign eff_dn      = bounce_turn ? ~dir_dn_s : dir_dn_s;

  sweep_step_calc #(.DIV_W(DIV_W)) u_calc (
    .cur       (divider),
    .step      (step_s),
    .target    (eff_tgt),
    .dir_dn    (eff_dn),
    .next      (nxt),
    .at_target (calc_at)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt_zero_q  <= 1'b1;
      divider     <= DIV_RESET;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      pcnt        <= '0;
      start_s     <= '0;
      tgt_s       <= '0;
      oth_s       <= '0;
      step_s      <= '0;
      per_s       <= PER_W'(1);
      dir_dn_s    <= 1'b0;
      bounce_s    <= 1'b0;
      fixed_s     <= 1'b0;
    end else begin
      cnt_zero_q  <= cnt_zero;
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_s  <= start_c;
              tgt_s    <= end_c;
              oth_s    <= start_c;
              step_s   <= div_step;
              per_s    <= (per_step == '0) ? PER_W'(1) : per_step;
              dir_dn_s <= (end_c < start_c);
              bounce_s <= (mode == MODE_BOUNCE);
              fixed_s  <= mode[1] | (div_step == '0);
              busy     <= 1'b1;
              state    <= ARM;
            end
          end
          ARM: begin
            if (bnd) begin
              divider     <= start_s;
              pcnt        <= '0;
              step_strobe <= 1'b1;
              state       <= SWEEP;
            end
          end
          SWEEP: begin
            if (bnd && !fixed_s) begin
              if (pcnt != per_s - PER_W'(1)) begin
                pcnt <= pcnt + PER_W'(1);
              end else begin
                pcnt <= '0;
                if (!at_tgt) begin
                  divider     <= nxt;
                  step_strobe <= 1'b1;
                end else if (!bounce_s) begin
                  sweep_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
                end else begin
                  tgt_s    <= oth_s;
                  oth_s    <= tgt_s;
                  dir_dn_s <= ~dir_dn_s;
                  if (!calc_at) begin
                    divider     <= nxt;
                    step_strobe <= 1'b1;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: table of sweeps plus hand sequences for timing corners.
module tb_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, cnt_zero;
  logic [1:0]  mode;
  logic [11:0] div_start, div_end, div_step;
  logic [7:0]  per_step;
  logic [11:0] divider;
  logic        busy, step_strobe, sweep_done;

  int n_tests = 0;
  int n_fail  = 0;
  int prev_div;

  always #5 clk = ~clk;

  freq_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .div_start   (div_start),
    .div_end     (div_end),
    .div_step    (div_step),
    .per_step    (per_step),
    .cnt_zero    (cnt_zero),
    .divider     (divider),
    .busy        (busy),
    .step_strobe (step_strobe),
    .sweep_done  (sweep_done)
  );

  typedef struct {
    logic [1:0]  m;
    logic [11:0] s;
    logic [11:0] e;
    logic [11:0] st;
    logic [7:0]  per;
    int          n;
    int          done_idx;
    int          exp_div[8];
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [1:0] m, input int s, input int e, input int st, input int per);
    mode      = m;
    div_start = 12'(s);
    div_end   = 12'(e);
    div_step  = 12'(st);
    per_step  = 8'(per);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    // Garbage on config inputs after acceptance; the shadow registers must hold.
    mode      = 2'd1;
    div_start = 12'd7;
    div_end   = 12'd4000;
    div_step  = 12'd1;
    per_step  = 8'd9;
  endtask

  // Raise cnt_zero; the update is visible right after the next edge.
  task automatic rise();
    cnt_zero = 1'b1;
    tick();
  endtask

  task automatic fall();
    tick();
    cnt_zero = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    vecs[0] = '{2'd0, 12'd100, 12'd96,   12'd2,    8'd2, 7,  6, '{100, 100, 98, 98, 96, 96, 96, 0}};
    vecs[1] = '{2'd0, 12'd100, 12'd95,   12'd3,    8'd1, 4,  3, '{100, 97, 95, 95, 0, 0, 0, 0}};
    vecs[2] = '{2'd0, 12'd10,  12'd4095, 12'd4000, 8'd1, 4,  3, '{10, 4010, 4095, 4095, 0, 0, 0, 0}};
    vecs[3] = '{2'd1, 12'd50,  12'd52,   12'd1,    8'd1, 7, -1, '{50, 51, 52, 51, 50, 51, 52, 0}};
    vecs[4] = '{2'd0, 12'd1,   12'd5,    12'd2,    8'd1, 3,  2, '{3, 5, 5, 0, 0, 0, 0, 0}};
    vecs[5] = '{2'd0, 12'd20,  12'd22,   12'd1,    8'd0, 4,  3, '{20, 21, 22, 22, 0, 0, 0, 0}};
    vecs[6] = '{2'd0, 12'd40,  12'd60,   12'd0,    8'd1, 4, -1, '{40, 40, 40, 40, 0, 0, 0, 0}};
    vecs[7] = '{2'd2, 12'd70,  12'd80,   12'd5,    8'd1, 3, -1, '{70, 70, 70, 0, 0, 0, 0, 0}};
    vecs[8] = '{2'd0, 12'd30,  12'd30,   12'd2,    8'd2, 3,  2, '{30, 30, 30, 0, 0, 0, 0, 0}};
    vecs[9] = '{2'd3, 12'd200, 12'd100,  12'd10,   8'd1, 3, -1, '{200, 200, 200, 0, 0, 0, 0, 0}};

    rst = 1'b1; start = 1'b0; stop = 1'b0; cnt_zero = 1'b1;
    mode = 2'd0; div_start = '0; div_end = '0; div_step = '0; per_step = '0;
    repeat (3) tick();
    chk("reset_divider", int'(divider), 99);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobe", int'(step_strobe), 0);
    chk("reset_done", int'(sweep_done), 0);
    rst = 1'b0;

    // cnt_zero already high at reset release must not count as a boundary.
    issue_start(2'd0, 100, 90, 5, 1);
    repeat (3) tick();
    chk("level_at_release_no_bnd", int'(divider), 99);
    chk("arm_busy", int'(busy), 1);
    cnt_zero = 1'b0;
    tick();

    // Long cnt_zero high: one boundary, update exactly one clk after the rise.
    cnt_zero = 1'b1;
    chk("before_edge_div", int'(divider), 99);
    tick();
    chk("long_hi_first_div", int'(divider), 100);
    chk("long_hi_strobe", int'(step_strobe), 1);
    repeat (4) tick();
    chk("long_hi_held_div", int'(divider), 100);
    chk("long_hi_strobe_clear", int'(step_strobe), 0);
    cnt_zero = 1'b0;
    tick();
    issue_start(2'd1, 10, 20, 1, 1);   // busy: must be ignored
    tick();
    rise();
    chk("busy_start_ignored_div", int'(divider), 95);
    repeat (4) tick();
    chk("long_hi_one_period", int'(divider), 95);
    cnt_zero = 1'b0;
    tick();
    rise();
    chk("sweep_to_end", int'(divider), 90);
    fall();
    rise();
    chk("end_done", int'(sweep_done), 1);
    chk("end_busy_low", int'(busy), 0);
    chk("end_div", int'(divider), 90);
    fall();

    // start and stop together: stop wins, stay IDLE.
    start = 1'b1; stop = 1'b1; mode = 2'd0; div_start = 12'd300; div_end = 12'd310;
    div_step = 12'd1; per_step = 8'd1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    rise();
    fall();
    chk("start_stop_div", int'(divider), 90);
    prev_div = 90;

    for (int v = 0; v < NV; v++) begin
      issue_start(vecs[v].m, int'(vecs[v].s), int'(vecs[v].e), int'(vecs[v].st), int'(vecs[v].per));
      chk($sformatf("v%0d_arm_busy", v), int'(busy), 1);
      chk($sformatf("v%0d_arm_hold", v), int'(divider), prev_div);
      for (int k = 0; k < vecs[v].n; k++) begin
        rise();
        chk($sformatf("v%0d_div%0d", v, k), int'(divider), vecs[v].exp_div[k]);
        chk($sformatf("v%0d_strobe%0d", v, k), int'(step_strobe),
            (k == 0 || vecs[v].exp_div[k] != vecs[v].exp_div[k-1]) ? 1 : 0);
        chk($sformatf("v%0d_done%0d", v, k), int'(sweep_done), (k == vecs[v].done_idx) ? 1 : 0);
        chk($sformatf("v%0d_busy%0d", v, k), int'(busy), (k == vecs[v].done_idx) ? 0 : 1);
        fall();
      end
      prev_div = vecs[v].exp_div[vecs[v].n - 1];
      if (vecs[v].done_idx < 0) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk($sformatf("v%0d_stop_busy", v), int'(busy), 0);
        chk($sformatf("v%0d_stop_div", v), int'(divider), prev_div);
        rise();
        chk($sformatf("v%0d_frozen_div", v), int'(divider), prev_div);
        chk($sformatf("v%0d_frozen_strobe", v), int'(step_strobe), 0);
        chk($sformatf("v%0d_stop_no_done", v), int'(sweep_done), 0);
        fall();
      end
    end

    // Reset in the middle of a sweep, then a fresh sweep.
    issue_start(2'd0, 200, 100, 10, 1);
    rise(); fall();
    rise();
    chk("pre_rst_div", int'(divider), 190);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_div", int'(divider), 99);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_strobe", int'(step_strobe), 0);
    chk("mid_rst_done", int'(sweep_done), 0);
    fall();
    issue_start(2'd0, 60, 62, 2, 1);
    rise();
    chk("post_rst_div0", int'(divider), 60);
    fall();
    rise();
    chk("post_rst_div1", int'(divider), 62);
    fall();
    rise();
    chk("post_rst_done", int'(sweep_done), 1);
    chk("post_rst_busy", int'(busy), 0);
    fall();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
